// File: rtl/switch_debounce.sv
// Slide-switch conditioner: two-flop synchronizer, per-bit debounce counter,
// rise/fall pulses and a sticky change mask with acknowledge.
module switch_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             change_ack,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] change_mask,
    output logic             change_pending
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             pending_q;

    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // Counting only while the synchronized level disagrees with the accepted one.
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == TERM_CNT) begin
                    stable_d[i] = s2_q[i];
                    rise_d[i]   = s2_q[i];
                    fall_d[i]   = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // New bits survive a coincident ack so no change is lost.
        mask_d = (change_ack ? '0 : mask_q) | rise_d | fall_d;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            mask_q    <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= sw_raw;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            mask_q    <= mask_d;
            pending_q <= |mask_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_stable      = stable_q;
    assign sw_rise        = rise_q;
    assign sw_fall        = fall_q;
    assign change_mask    = mask_q;
    assign change_pending = pending_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: a sliding-window reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_switch_debounce;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk_100MHz = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic         change_ack;
    logic [W-1:0] sw_stable, sw_rise, sw_fall, change_mask;
    logic         change_pending;

    int errors = 0;
    int checks = 0;

    switch_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (5)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .sw_raw        (sw_raw),
        .change_ack    (change_ack),
        .sw_stable     (sw_stable),
        .sw_rise       (sw_rise),
        .sw_fall       (sw_fall),
        .change_mask   (change_mask),
        .change_pending(change_pending)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a bit flips once the last D synchronized samples (sample ages
    // 2..D+1 edges back) all disagree with the accepted level.
    typedef struct packed {
        logic [W-1:0] stable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] mask;
        logic         pending;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] hist [D+2];
    logic [W-1:0] m_stable, m_mask;
    exp_t         m_e;
    logic         all_diff;

    always @(posedge clk_100MHz) begin
        m_e = '0;
        if (reset) begin
            for (int k = 0; k < D + 2; k++) hist[k] = '0;
            m_stable = '0;
            m_mask   = '0;
        end else begin
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = sw_raw;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++)
                    if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_stable[b]) m_e.fall[b] = 1'b1;
                    else             m_e.rise[b] = 1'b1;
                    m_stable[b] = ~m_stable[b];
                end
            end
            m_mask    = (change_ack ? '0 : m_mask) | m_e.rise | m_e.fall;
            m_e.stable  = m_stable;
            m_e.mask    = m_mask;
            m_e.pending = |m_mask;
        end
        exp_q.push_back(m_e);
    end

    exp_t mon_e;
    always @(negedge clk_100MHz) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sb_stable",  32'(sw_stable),      32'(mon_e.stable));
            check("sb_rise",    32'(sw_rise),        32'(mon_e.rise));
            check("sb_fall",    32'(sw_fall),        32'(mon_e.fall));
            check("sb_mask",    32'(change_mask),    32'(mon_e.mask));
            check("sb_pending", 32'(change_pending), 32'(mon_e.pending));
        end
    end

    int rise_cnt [W];
    int fall_cnt [W];
    initial for (int b = 0; b < W; b++) begin
        rise_cnt[b] = 0;
        fall_cnt[b] = 0;
    end
    always @(negedge clk_100MHz) begin
        for (int b = 0; b < W; b++) begin
            if (sw_rise[b] === 1'b1) rise_cnt[b]++;
            if (sw_fall[b] === 1'b1) fall_cnt[b]++;
        end
    end

    // Index i means "just after edge i", edge 0 being the first edge after the call.
    task automatic watch(input int n, input int b, output int nrise, output int first);
        nrise = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100MHz);
            if (sw_rise[b] === 1'b1) begin
                nrise++;
                if (first < 0) first = i;
            end
        end
    endtask

    int nr, first, r0, f0, hold;

    initial begin
        reset      = 1'b1;
        sw_raw     = '0;
        change_ack = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        repeat (40) @(negedge clk_100MHz);
        check("idle_stable", 32'(sw_stable), 32'h0);
        check("idle_mask", 32'(change_mask), 32'h0);

        // Basic acceptance of 0x05
        sw_raw = 8'h05;
        watch(30, 0, nr, first);
        check("t2_rise_edge", 32'(first), 32'd17);
        check("t2_rise_count", 32'(nr), 32'd1);
        check("t2_stable", 32'(sw_stable), 32'h05);
        check("t2_mask", 32'(change_mask), 32'h05);
        check("t2_pending", 32'(change_pending), 32'h1);

        // Ack on the same edge that bit 1 is accepted
        sw_raw = 8'h07;
        repeat (17) @(negedge clk_100MHz);
        change_ack = 1'b1;
        @(negedge clk_100MHz);
        change_ack = 1'b0;
        check("t5_rise", 32'(sw_rise), 32'h02);
        check("t5_mask", 32'(change_mask), 32'h02);
        check("t5_pending", 32'(change_pending), 32'h1);
        change_ack = 1'b1;
        @(negedge clk_100MHz);
        change_ack = 1'b0;
        check("t5_mask_clr", 32'(change_mask), 32'h0);
        check("t5_pending_clr", 32'(change_pending), 32'h0);

        // 15-cycle glitch on bit 3 is rejected, 16-cycle pulse is accepted
        r0 = rise_cnt[3];
        f0 = fall_cnt[3];
        sw_raw = 8'h0F;
        repeat (15) @(negedge clk_100MHz);
        sw_raw = 8'h07;
        repeat (30) @(negedge clk_100MHz);
        check("t3_glitch_rise", 32'(rise_cnt[3] - r0), 32'd0);
        check("t3_glitch_stable", 32'(sw_stable), 32'h07);
        check("t3_glitch_mask", 32'(change_mask), 32'h0);
        sw_raw = 8'h0F;
        repeat (16) @(negedge clk_100MHz);
        sw_raw = 8'h07;
        repeat (40) @(negedge clk_100MHz);
        check("t3_pulse_rise", 32'(rise_cnt[3] - r0), 32'd1);
        check("t3_pulse_fall", 32'(fall_cnt[3] - f0), 32'd1);

        // Bounce on bit 7, then settle high
        r0 = rise_cnt[7];
        for (int t = 0; t < 20; t++) begin
            sw_raw = sw_raw ^ 8'h80;
            repeat (5) @(negedge clk_100MHz);
        end
        sw_raw = sw_raw | 8'h80;
        watch(40, 7, nr, first);
        check("t4_rise_edge", 32'(first), 32'd17);
        check("t4_rise_total", 32'(rise_cnt[7] - r0), 32'd1);

        // Reset while cnt[2] is 10
        sw_raw = 8'h00;
        repeat (40) @(negedge clk_100MHz);
        change_ack = 1'b1;
        @(negedge clk_100MHz);
        change_ack = 1'b0;
        sw_raw = 8'h04;
        repeat (12) @(negedge clk_100MHz);
        reset = 1'b1;
        @(negedge clk_100MHz);
        reset = 1'b0;
        check("t6_stable", 32'(sw_stable), 32'h0);
        check("t6_pulses", 32'(sw_rise | sw_fall), 32'h0);
        check("t6_mask", 32'({change_pending, change_mask}), 32'h0);
        watch(40, 2, nr, first);
        check("t6_rise_edge", 32'(first), 32'd17);
        check("t6_rise_count", 32'(nr), 32'd1);

        // Random levels, hold times and acks, with the odd reset
        for (int t = 0; t < 60; t++) begin
            sw_raw = W'($urandom);
            hold   = $urandom_range(1, 25);
            for (int c = 0; c < hold; c++) begin
                change_ack = ($urandom_range(0, 7) == 0);
                reset      = ($urandom_range(0, 199) == 0);
                @(negedge clk_100MHz);
            end
        end
        change_ack = 1'b0;
        reset      = 1'b0;
        repeat (40) @(negedge clk_100MHz);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
